// File: rtl/dly_meas_pkg.sv
// Shared types and constants for the multi-channel propagation-delay meter.
package dly_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        COUNT,
        FINISH
    } state_e;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchroniser for the asynchronous target returns; resets to 0.
module sync_2ff
    import dly_meas_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/dly_meas_ctrl.sv
// Launches a stimulus edge into one delay path, counts cycles until the target edge returns
// and averages the count over 2^rep_log2 runs.
module dly_meas_ctrl
    import dly_meas_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned REP_MAX    = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [$clog2(N_CH)-1:0]      ch_sel_i,
    input  logic [$clog2(REP_MAX+1)-1:0] rep_log2_i,
    input  logic                         trig_fall_i,
    input  logic                         targ_rise_i,
    input  logic [N_CH-1:0]              targ_i,
    output logic [N_CH-1:0]              stim_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic [CNT_W-1:0]             result_o
);

    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned REP_W = $clog2(REP_MAX + 1);
    localparam int unsigned SUM_W = CNT_W + REP_MAX;
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned RUN_W = REP_MAX + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CH_W-1:0]    r_ch;
    logic [REP_W-1:0]   r_rep;
    logic               r_trig_fall;
    logic               r_targ_rise;
    logic [SET_W-1:0]   r_settle;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   r_sum;
    logic [RUN_W-1:0]   r_runs_left;
    logic [N_CH-1:0]    r_stim;
    logic [N_CH-1:0]    r_targ_prev;
    logic               r_done;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_result;
    logic [N_CH-1:0]    w_targ_sync;
    logic [SUM_W-1:0]   w_avg;
    logic               w_hit;
    logic               w_tmo;
    logic               w_settled;
    logic               w_last_run;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (targ_i[g]),
            .q_o   (w_targ_sync[g])
        );
    end

    // Edge detect against the previous synced sample; only meaningful while counting.
    assign w_hit = (r_state == COUNT) &&
                   (w_targ_sync[r_ch] != r_targ_prev[r_ch]) &&
                   (w_targ_sync[r_ch] == r_targ_rise);
    assign w_tmo      = (r_state == COUNT) && !w_hit && (r_cnt == CNT_W'(TIMEOUT));
    assign w_settled  = (r_settle == SET_W'(SETTLE_CYC - 1));
    assign w_last_run = (r_runs_left == '0);
    assign w_avg      = r_sum >> r_rep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start_i) w_state_nxt = SETTLE;
            SETTLE:  if (w_settled) w_state_nxt = LAUNCH;
            LAUNCH:  w_state_nxt = COUNT;
            COUNT: begin
                if (w_hit) begin
                    w_state_nxt = w_last_run ? FINISH : SETTLE;
                end else if (w_tmo) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == SETTLE) || (r_state == LAUNCH) || (r_state == COUNT);
    end

    assign stim_o    = r_stim;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
    assign result_o  = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch        <= '0;
            r_rep       <= '0;
            r_trig_fall <= 1'b1;
            r_targ_rise <= 1'b1;
            r_settle    <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_runs_left <= '0;
            r_stim      <= '1;
            r_targ_prev <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_result    <= '0;
        end else begin
            r_targ_prev <= w_targ_sync;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_ch        <= ch_sel_i;
                        r_rep       <= rep_log2_i;
                        r_trig_fall <= trig_fall_i;
                        r_targ_rise <= targ_rise_i;
                        r_sum       <= '0;
                        r_runs_left <= RUN_W'((1 << rep_log2_i) - 1);
                        r_timeout   <= 1'b0;
                        r_settle    <= '0;
                        r_stim      <= {N_CH{trig_fall_i}};
                    end
                end
                SETTLE: r_settle <= r_settle + SET_W'(1);
                LAUNCH: begin
                    // Stimulus and counter start on the same edge so a zero-delay path reads 2.
                    r_stim[r_ch] <= ~r_trig_fall;
                    r_cnt        <= '0;
                end
                COUNT: begin
                    if (w_hit) begin
                        r_sum       <= r_sum + SUM_W'(r_cnt);
                        r_runs_left <= r_runs_left - RUN_W'(1);
                        r_settle    <= '0;
                        r_stim      <= {N_CH{r_trig_fall}};
                    end else if (w_tmo) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FINISH: begin
                    r_done   <= 1'b1;
                    r_stim   <= {N_CH{r_trig_fall}};
                    r_result <= r_timeout ? '1 : w_avg[CNT_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dly_meas_ctrl.sv
// Scoreboarded bench: a delay-line path model answers each launch, a reference model predicts
// the averaged result, and a monitor checks every done_o against the queued expectation.
module tb_dly_meas_ctrl;

    localparam int N_CH       = 4;
    localparam int CNT_W      = 16;
    localparam int REP_MAX    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int TIMEOUT    = 1000;
    localparam int NONE       = -1;

    typedef struct {
        int d1;
        int d2;
    } run_t;

    typedef struct {
        int result;
        int tmo;
        int launches;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [1:0]       ch_sel_i = '0;
    logic [2:0]       rep_log2_i = '0;
    logic             trig_fall_i = 1'b1;
    logic             targ_rise_i = 1'b1;
    logic [N_CH-1:0]  targ_i = '0;
    logic [N_CH-1:0]  stim_o;
    logic             busy_o;
    logic             done_o;
    logic             timeout_o;
    logic [CNT_W-1:0] result_o;

    always #5 clk = ~clk;

    dly_meas_ctrl #(
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .REP_MAX    (REP_MAX),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .ch_sel_i    (ch_sel_i),
        .rep_log2_i  (rep_log2_i),
        .trig_fall_i (trig_fall_i),
        .targ_rise_i (targ_rise_i),
        .targ_i      (targ_i),
        .stim_o      (stim_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .result_o    (result_o)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    run_t plan[$];
    run_t path_q[$];
    exp_t exp_q[$];
    int   cur_ch = 0;
    bit   cur_idle = 1'b1;
    int   launches = 0;
    int   viol = 0;
    int   age[N_CH];
    run_t act[N_CH];
    bit   tog;
    exp_t e_mon;

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference: each run reads delay+2 on the first edge of the wanted polarity; the first
    // target toggle is a rising edge exactly when the stimulus idles high.
    function automatic exp_t model(int rep, bit tf, bit tr);
        exp_t e;
        int   sum = 0;
        int   runs = 1 << rep;
        e.tmo = 0;
        e.launches = runs;
        for (int i = 0; i < runs; i++) begin
            int c = -1;
            if (i < plan.size() && plan[i].d1 != NONE) begin
                if (tf == tr) c = plan[i].d1 + 2;
                else if (plan[i].d2 != NONE) c = plan[i].d2 + 2;
            end
            if (c < 0 || c > TIMEOUT) begin
                e.tmo = 1;
                e.launches = i + 1;
                break;
            end
            sum += c;
        end
        e.result = (e.tmo != 0) ? 32'hFFFF : (sum >> rep);
        return e;
    endfunction

    // Monitor + path model: targ follows inverted stim, toggling d1 (and d2) cycles after launch.
    always @(negedge clk) begin
        if (!rst_n) begin
            launches = 0;
            viol = 0;
        end else begin
            if (busy_o) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (c != cur_ch && stim_o[c] != cur_idle) viol++;
                end
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done_o=1, want no pending measurement");
                end else begin
                    e_mon = exp_q.pop_front();
                    check("result", int'(result_o), e_mon.result);
                    check("timeout", int'(timeout_o), e_mon.tmo);
                    check("launches", launches, e_mon.launches);
                    check("idle_stim_violations", viol, 0);
                end
                launches = 0;
                viol = 0;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            tog = 1'b0;
            if (!rst_n || !busy_o || stim_o[c] == cur_idle) begin
                age[c] = 0;
            end else begin
                if (age[c] == 0) begin
                    if (c == cur_ch) launches++;
                    if (path_q.size() > 0) begin
                        act[c] = path_q.pop_front();
                    end else begin
                        act[c].d1 = NONE;
                        act[c].d2 = NONE;
                    end
                end
                tog = (act[c].d1 != NONE && age[c] >= act[c].d1) ^
                      (act[c].d2 != NONE && age[c] >= act[c].d2);
                age[c]++;
            end
            targ_i[c] = ~cur_idle ^ tog;
        end
    end

    task automatic add(int d1, int d2);
        run_t r;
        r.d1 = d1;
        r.d2 = d2;
        plan.push_back(r);
    endtask

    task automatic issue(int ch, int rep, bit tf, bit tr);
        exp_q.push_back(model(rep, tf, tr));
        path_q = plan;
        cur_ch = ch;
        cur_idle = tf;
        ch_sel_i = 2'(ch);
        rep_log2_i = 3'(rep);
        trig_fall_i = tf;
        targ_rise_i = tr;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (done_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: got no done_o in %0d cycles, want one", n);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_stim", int'(stim_o), 4'hF);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_result", int'(result_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        plan.delete(); add(5, NONE);
        issue(0, 0, 1'b1, 1'b1);
        wait_done(n);

        plan.delete(); add(4, NONE); add(6, NONE); add(5, NONE); add(9, NONE);
        issue(2, 2, 1'b1, 1'b1);
        wait_done(n);

        // Dead path: timeout, done_o roughly SETTLE_CYC+1+TIMEOUT cycles after start.
        plan.delete(); add(NONE, NONE);
        issue(1, 0, 1'b1, 1'b1);
        wait_done(n);
        n_cmp++;
        if (n < SETTLE_CYC + 1 + TIMEOUT || n > SETTLE_CYC + 1 + TIMEOUT + 4) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", n,
                     SETTLE_CYC + 1 + TIMEOUT, SETTLE_CYC + 1 + TIMEOUT + 4);
        end

        plan.delete(); add(3, NONE);
        issue(3, 0, 1'b0, 1'b0);
        wait_done(n);

        // Wrong-polarity pulse first (ignored), then the wanted edge at 8.
        plan.delete(); add(3, 8);
        issue(0, 0, 1'b1, 1'b0);
        wait_done(n);

        // start_i while busy with a different config must be ignored.
        plan.delete(); add(12, NONE); add(10, NONE);
        issue(1, 1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        ch_sel_i = 2'd3; rep_log2_i = 3'd0; trig_fall_i = 1'b0; targ_rise_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(n);
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-COUNT, then a clean measurement.
        plan.delete(); add(30, NONE);
        issue(2, 0, 1'b1, 1'b1);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        path_q.delete();
        cur_idle = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        plan.delete(); add(7, NONE); add(2, NONE);
        issue(2, 1, 1'b1, 1'b1);
        wait_done(n);

        for (int k = 0; k < 8; k++) begin
            int ch = $urandom_range(0, N_CH - 1);
            int rep = (k == 0) ? REP_MAX : $urandom_range(0, 3);
            bit tf = 1'($urandom_range(0, 1));
            bit tr = ($urandom_range(0, 3) == 0) ? ~tf : tf;
            plan.delete();
            for (int r = 0; r < (1 << rep); r++) begin
                int d1 = $urandom_range(0, 40);
                int d2;
                if (tf != tr) d2 = d1 + 2 + $urandom_range(0, 20);
                else d2 = ($urandom_range(0, 1) == 1) ? NONE : d1 + 2 + $urandom_range(0, 5);
                add(d1, d2);
            end
            issue(ch, rep, tf, tr);
            wait_done(n);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
